// File: rtl/drive_pkg.sv
// Shared definitions for the drive command path: mode codes, frame header,
// movement bit positions and scheduler FSM states.
package drive_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_SEMI   = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam logic [1:0] FRAME_HDR = 2'b10;

    localparam int unsigned MV_FWD   = 0;
    localparam int unsigned MV_BACK  = 1;
    localparam int unsigned MV_LEFT  = 2;
    localparam int unsigned MV_RIGHT = 3;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    // Opposing requests cancel each other rather than letting one side win.
    function automatic logic [3:0] sanitise_move(input logic [3:0] mv);
        logic [3:0] res;
        res = mv;
        if (mv[MV_FWD] && mv[MV_BACK]) begin
            res[MV_FWD]  = 1'b0;
            res[MV_BACK] = 1'b0;
        end
        if (mv[MV_LEFT] && mv[MV_RIGHT]) begin
            res[MV_LEFT]  = 1'b0;
            res[MV_RIGHT] = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running frame period counter; tick is high for the last count of
// each period.
module frame_timer #(
    parameter int unsigned FRAME_DIV = 1_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/drive_cmd_scheduler.sv
// Builds one command frame per frame period for the car UART link and
// latches the detector byte coming back.
module drive_cmd_scheduler
    import drive_pkg::*;
#(
    parameter int unsigned FRAME_DIV    = 1_000_000,
    parameter int unsigned BARRIER_HOLD = 4
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] mode_sel,
    input  logic [3:0] man_move,
    input  logic [3:0] semi_move,
    input  logic [3:0] auto_move,
    input  logic       place_req,
    input  logic       destroy_req,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [3:0] detect,
    output logic       overrun
);

    localparam int unsigned BW = $clog2(BARRIER_HOLD + 1);
    localparam logic [BW-1:0] HOLD_VAL = BW'(BARRIER_HOLD);

    state_e        r_state;
    state_e        w_next;
    logic          w_tick;
    logic          w_capture;
    logic          w_accept;
    mode_e         r_mode;
    logic          r_switch_pend;
    logic          r_frame_sw;
    logic [BW-1:0] r_place_cnt;
    logic [BW-1:0] r_destroy_cnt;
    logic [7:0]    r_tx_data;
    logic [3:0]    r_detect;
    logic          r_overrun;
    logic [3:0]    w_move_sel;
    logic [3:0]    w_move;
    logic          w_place_bit;
    logic          w_destroy_bit;
    logic          w_unused_rx;

    frame_timer #(
        .FRAME_DIV(FRAME_DIV)
    ) u_frame_timer (
        .sys_clk(sys_clk),
        .rst    (rst),
        .tick   (w_tick)
    );

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_next    = SEND;
                    w_capture = 1'b1;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    w_accept = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_move_sel = '0;
        case (r_mode)
            MODE_MANUAL: w_move_sel = man_move;
            MODE_SEMI:   w_move_sel = semi_move;
            MODE_AUTO:   w_move_sel = auto_move;
            default:     w_move_sel = '0;
        endcase
        w_move = sanitise_move(w_move_sel);
        if (!power || r_switch_pend) begin
            w_move = '0;
        end
    end

    // Masked by power too, so a frame captured as power drops carries no barrier.
    assign w_place_bit   = power && (r_place_cnt != '0);
    assign w_destroy_bit = power && (r_destroy_cnt != '0);

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_tx_data  <= {FRAME_HDR, 6'b000000};
            r_frame_sw <= 1'b0;
        end else if (w_capture) begin
            r_tx_data  <= {FRAME_HDR, w_destroy_bit, w_place_bit, w_move};
            r_frame_sw <= r_switch_pend;
        end
    end

    // Pending clears only once the stop frame that was built for it is taken.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_mode        <= MODE_MANUAL;
            r_switch_pend <= 1'b1;
        end else begin
            r_mode <= mode_e'(mode_sel);
            if (mode_e'(mode_sel) != r_mode) begin
                r_switch_pend <= 1'b1;
            end else if (w_accept && r_frame_sw) begin
                r_switch_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_place_cnt   <= '0;
            r_destroy_cnt <= '0;
        end else if (!power) begin
            r_place_cnt   <= '0;
            r_destroy_cnt <= '0;
        end else if (destroy_req) begin
            r_destroy_cnt <= HOLD_VAL;
            r_place_cnt   <= '0;
        end else if (place_req) begin
            r_place_cnt   <= HOLD_VAL;
            r_destroy_cnt <= '0;
        end else if (w_accept) begin
            if (r_tx_data[4] && (r_place_cnt != '0)) begin
                r_place_cnt <= r_place_cnt - 1'b1;
            end
            if (r_tx_data[5] && (r_destroy_cnt != '0)) begin
                r_destroy_cnt <= r_destroy_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= (r_state == SEND) && w_tick;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_detect <= '0;
        end else if (rx_valid && (rx_data[7:6] != 2'b11)) begin
            r_detect <= rx_data[3:0];
        end
    end

    assign w_unused_rx = ^rx_data[5:4];

    assign tx_valid = (r_state == SEND);
    assign tx_data  = r_tx_data;
    assign detect   = r_detect;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// Directed bench for drive_cmd_scheduler with FRAME_DIV=8, BARRIER_HOLD=2.
module tb_drive_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       power = 1'b1;
    logic [1:0] mode_sel = 2'b00;
    logic [3:0] man_move = 4'b0001;
    logic [3:0] semi_move = 4'b0100;
    logic [3:0] auto_move = 4'b0010;
    logic       place_req = 1'b0;
    logic       destroy_req = 1'b0;
    logic       tx_ready = 1'b1;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [3:0] detect;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    drive_cmd_scheduler #(
        .FRAME_DIV   (8),
        .BARRIER_HOLD(2)
    ) dut (
        .sys_clk    (clk),
        .rst        (rst),
        .power      (power),
        .mode_sel   (mode_sel),
        .man_move   (man_move),
        .semi_move  (semi_move),
        .auto_move  (auto_move),
        .place_req  (place_req),
        .destroy_req(destroy_req),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .detect     (detect),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Waits (bounded) for an accepted frame; returns just after the acceptance edge.
    task automatic get_frame(output logic [7:0] d, output int t, output bit ok);
        ok = 1'b0;
        d  = 8'hxx;
        t  = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                d = tx_data;
                @(posedge clk);
                #1;
                t  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        int t1, t2;
        bit ok;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h80) begin errors++; $display("FAIL reset_tx_data got=%h exp=80", tx_data); end
        checks++; if (detect !== 4'h0) begin errors++; $display("FAIL reset_detect got=%h exp=0", detect); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        rst = 1'b1;
        get_frame(d, t1, ok);
        checks++; if (!ok || d !== 8'h80) begin errors++; $display("FAIL first_frame got=%h ok=%0d exp=80", d, ok); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL one_cycle_valid got=%b exp=0", tx_valid); end
        get_frame(d, t2, ok);
        checks++; if (!ok || d !== 8'h81) begin errors++; $display("FAIL second_frame got=%h ok=%0d exp=81", d, ok); end
        checks++; if (t2 - t1 != 8) begin errors++; $display("FAIL frame_spacing got=%0d exp=8", t2 - t1); end
    endtask

    task automatic test_sanitise;
        logic [7:0] d;
        int t;
        bit ok;
        man_move = 4'b0011;
        get_frame(d, t, ok);
        checks++; if (!ok || d !== 8'h80) begin errors++; $display("FAIL fwd_back_cancel got=%h exp=80", d); end
        man_move = 4'b1100;
        get_frame(d, t, ok);
        checks++; if (!ok || d !== 8'h80) begin errors++; $display("FAIL left_right_cancel got=%h exp=80", d); end
        man_move = 4'b0101;
        get_frame(d, t, ok);
        checks++; if (!ok || d !== 8'h85) begin errors++; $display("FAIL fwd_left got=%h exp=85", d); end
        man_move = 4'b0001;
        get_frame(d, t, ok);
        checks++; if (!ok || d !== 8'h81) begin errors++; $display("FAIL fwd_restore got=%h exp=81", d); end
    endtask

    task automatic test_barrier;
        logic [7:0] d;
        int t;
        bit ok;
        logic [7:0] exp_place [3];
        logic [7:0] exp_destroy [3];
        exp_place   = '{8'h91, 8'h91, 8'h81};
        exp_destroy = '{8'hA1, 8'hA1, 8'h81};
        place_req = 1'b1;
        @(posedge clk); #1;
        place_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            get_frame(d, t, ok);
            checks++; if (!ok || d !== exp_place[i]) begin errors++; $display("FAIL place_frame%0d got=%h exp=%h", i, d, exp_place[i]); end
        end
        place_req   = 1'b1;
        destroy_req = 1'b1;
        @(posedge clk); #1;
        place_req   = 1'b0;
        destroy_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            get_frame(d, t, ok);
            checks++; if (!ok || d !== exp_destroy[i]) begin errors++; $display("FAIL destroy_frame%0d got=%h exp=%h", i, d, exp_destroy[i]); end
        end
    endtask

    task automatic test_stall;
        logic [7:0] d, held;
        int t1, t2, ovr;
        bit ok, stable;
        tx_ready = 1'b0;
        wait_valid(ok);
        held = tx_data;
        checks++; if (!ok || held !== 8'h81) begin errors++; $display("FAIL stall_frame got=%h ok=%0d exp=81", held, ok); end
        ovr = 0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_data !== held || tx_valid !== 1'b1) stable = 1'b0;
            if (overrun === 1'b1) ovr++;
        end
        checks++; if (!stable) begin errors++; $display("FAIL stall_stable got=0 exp=1"); end
        checks++; if (ovr != 2) begin errors++; $display("FAIL overrun_count got=%0d exp=2", ovr); end
        tx_ready = 1'b1;
        get_frame(d, t1, ok);
        checks++; if (!ok || d !== held) begin errors++; $display("FAIL stall_accept got=%h exp=%h", d, held); end
        get_frame(d, t1, ok);
        get_frame(d, t2, ok);
        checks++; if (!ok || t2 - t1 != 8) begin errors++; $display("FAIL periodic_after_stall got=%0d exp=8", t2 - t1); end
    endtask

    task automatic test_mode_switch;
        logic [7:0] d;
        int t;
        bit ok;
        mode_sel  = 2'b10;
        auto_move = 4'b0010;
        get_frame(d, t, ok);
        checks++; if (!ok || d !== 8'h80) begin errors++; $display("FAIL switch_stop got=%h exp=80", d); end
        get_frame(d, t, ok);
        checks++; if (!ok || d !== 8'h82) begin errors++; $display("FAIL switch_auto got=%h exp=82", d); end
    endtask

    task automatic test_power;
        logic [7:0] d;
        int t;
        bit ok;
        place_req = 1'b1;
        @(posedge clk); #1;
        place_req = 1'b0;
        power = 1'b0;
        get_frame(d, t, ok);
        checks++; if (!ok || d !== 8'h80) begin errors++; $display("FAIL power_off got=%h exp=80", d); end
        power = 1'b1;
        get_frame(d, t, ok);
        checks++; if (!ok || d !== 8'h82) begin errors++; $display("FAIL barrier_cleared got=%h exp=82", d); end
    endtask

    task automatic test_detect;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h85;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++; if (detect !== 4'b0101) begin errors++; $display("FAIL detect_load got=%b exp=0101", detect); end
        rx_valid = 1'b1;
        rx_data  = 8'hC3;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++; if (detect !== 4'b0101) begin errors++; $display("FAIL detect_hold got=%b exp=0101", detect); end
    endtask

    task automatic test_reset_mid_send;
        logic [7:0] d;
        int t;
        bit ok;
        tx_ready = 1'b0;
        wait_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_send_wait got=timeout exp=valid"); end
        rst = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_drop_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h80) begin errors++; $display("FAIL reset_drop_data got=%h exp=80", tx_data); end
        @(negedge clk);
        rst = 1'b1;
        tx_ready = 1'b1;
        get_frame(d, t, ok);
        checks++; if (!ok || d !== 8'h80) begin errors++; $display("FAIL post_reset_stop got=%h exp=80", d); end
    endtask

    initial begin
        test_reset();
        test_sanitise();
        test_barrier();
        test_stall();
        test_mode_switch();
        test_power();
        test_detect();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/drive_cmd_scheduler.md
# drive_cmd_scheduler

Sequences the 8-bit command frame sent to the simulated car's UART link. It selects the movement source (manual, semi-auto or auto driver) by mode, sanitises the movement bits, and stretches one-cycle barrier requests over several frames. It issues one frame per frame period to the UART transmitter through a valid/ready handshake, and latches the returned detector byte. It sits between the driving-mode logic and `uart_top`.

## Interface
- `FRAME_DIV`, 1_000_000: sys_clk cycles per frame period (100 Hz at 100 MHz); must be ≥ 4.
- `BARRIER_HOLD`, 4: number of accepted frames that carry a barrier bit after its request; must be ≥ 1.

- `sys_clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `power`  in  1  engine power; 0 forces a safe frame.
- `mode_sel`  in  2  00 manual, 01 semi-auto, 10 auto, 11 reserved (movement 0000).
- `man_move`, `semi_move`, `auto_move`  in  4 each  movement requests: [0] fwd, [1] back, [2] left, [3] right.
- `place_req`, `destroy_req`  in  1  single-cycle barrier request pulses.
- `tx_ready`  in  1  UART can accept a byte.
- `tx_valid`  out  1  frame offered.
- `tx_data`  out  8  frame {2'b10, destroy, place, move[3:0]}.
- `rx_valid`  in  1  detector byte received.
- `rx_data`  in  8  detector byte.
- `detect`  out  4  registered {back, right, left, front} = rx_data[3:0].
- `overrun`  out  1  one-cycle pulse when a frame tick arrives while a frame is still pending.

## Operation
- Frame timer counts 0..FRAME_DIV-1 and wraps. It produces a one-cycle `tick` at count FRAME_DIV-1 and runs continuously, including during SEND.
- FSM states:
  - IDLE: waits for `tick`. On `tick`, goes to SEND and captures the frame.
  - SEND: holds `tx_valid`=1 with `tx_data` stable. On valid&ready, returns to IDLE.
- `tick` in SEND: the frame is not replaced and `overrun` pulses. The tick is dropped, not queued.
- Frame capture, in order:
  - Select movement by the registered `mode_sel`.
  - If fwd&back are both set, clear both. If left&right are both set, clear both.
  - If `power`=0, movement=0000.
  - If a mode change is pending, movement=0000 and the pending flag clears on acceptance.
- Mode change: `mode_sel` is registered each cycle. Any difference between the new and previous value sets `switch_pend`, so exactly one stop frame is sent before the new source is used. A further change while pending keeps one stop frame.
- Barrier:
  - A `place_req` pulse loads `place_cnt`=BARRIER_HOLD; a `destroy_req` pulse loads `destroy_cnt`=BARRIER_HOLD.
  - A frame's place bit = (`place_cnt`≠0); its destroy bit = (`destroy_cnt`≠0).
  - Each nonzero counter decrements on acceptance of a frame that carried its bit.
  - Both pulses in the same cycle: destroy wins and place is ignored.
  - A place request while `destroy_cnt`≠0 clears `destroy_cnt`, and vice versa. Only one barrier bit is ever set.
  - A new request during a hold reloads the counter.
  - A request arriving in the acceptance cycle wins over the decrement.
- `power`=0 clears both barrier counters every cycle. Frames continue so the device sees stop.
- `detect` loads `rx_data[3:0]` on `rx_valid`, but only when `rx_data[7:6]`≠2'b11. Otherwise it holds its value.
- Reset values:
  - `tx_valid` 0, `tx_data` 8'h80, `detect` 0, `overrun` 0.
  - FSM in IDLE, timer 0, counters 0.
  - `switch_pend` 1, so the first frame after reset is a stop frame.
  - Mode register 00.
- Reset mid-SEND drops the frame immediately (`tx_valid` 0 asynchronously).

## Timing
- `tick` at edge N → `tx_valid`=1 and `tx_data` valid after edge N+1.
- Acceptance at the first edge where `tx_valid`&`tx_ready` are both 1. `tx_valid`=0 after that edge.
- If `tx_ready` is held at 1, each frame is valid for exactly one cycle.
- `tx_data` holds its last value while idle.
- Inputs are sampled on the capture edge only. Changes during SEND do not alter the offered frame.
- `detect` updates one cycle after `rx_valid`.

## Structure
- Shared package `drive_pkg`:
  - mode encodings (MODE_MANUAL/SEMI/AUTO/RSVD);
  - FRAME_HDR = 2'b10;
  - movement bit indices;
  - FSM state typedef (IDLE, SEND).
- Sub-module `frame_timer`, parameter FRAME_DIV, outputs `tick`. The rest of the logic is flat in `drive_cmd_scheduler`.

## Test plan
- Reset release, FRAME_DIV=8, `tx_ready`=1, manual, man_move=0001 → first frame 8'h80, second 8'h81; frames 8 cycles apart, each valid for one cycle.
- man_move=0011 and 1100 → frames carry movement 0000; man_move=0101 → 8'h85.
- `place_req` pulse, BARRIER_HOLD=2 → two accepted frames with bit4 set (8'h91 with fwd), the third with it clear. Simultaneous `place_req`+`destroy_req` → only bit5 set.
- Hold `tx_ready`=0 for 20 cycles with FRAME_DIV=8 → `tx_data` stable and `overrun` pulses twice. Raise ready → one acceptance, then a return to periodic frames.
- Mode switch 00→10 with man_move=0001, auto_move=0010 → one frame 8'h80, then 8'h82. `power`=0 with a pending barrier → 8'h80 and barrier counters cleared.
- `rx_valid` with rx_data=8'h85 → `detect`=0101 next cycle; rx_data=8'hC3 → `detect` unchanged. Assert `rst` during SEND → `tx_valid` low immediately.
